// File: rtl/sfx_event_scheduler.sv
// Sound-effect sequencer: latches collision request edges, plays one frame-stepped effect at a time.
// Request-to-voice latency is two clocks from an idle start; higher-priority requests preempt immediately.
module sfx_event_scheduler #(
    parameter int SFX_FRAMES      = 8,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic [2:0] req,
    output logic       gate,
    output logic [1:0] sfx_id,
    output logic [3:0] step,
    output logic [7:0] note,
    output logic       done,
    output logic [2:0] pending
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_COOL = 2'd2;

    localparam logic [3:0] LAST_STEP = 4'(SFX_FRAMES - 1);
    localparam logic [3:0] CD_LAST   = 4'(COOLDOWN_FRAMES - 1);

    logic [1:0] state;
    logic [2:0] req_q;
    logic [3:0] cd_cnt;
    logic [2:0] set_vec;
    logic [2:0] grant_oh;
    logic [1:0] top_id;
    logic       do_grant;
    logic [7:0] step8;

    assign set_vec = (req & ~req_q) & {3{enable}};

    // Effect ids double as priority ranks, so preemption is a plain magnitude compare.
    always_comb begin
        top_id = 2'd0;
        if (pending[2])      top_id = 2'd3;
        else if (pending[1]) top_id = 2'd2;
        else if (pending[0]) top_id = 2'd1;
    end

    assign grant_oh = (top_id == 2'd0) ? 3'b000 : (3'b001 << (top_id - 2'd1));
    assign do_grant = ((state == ST_IDLE) && (top_id != 2'd0)) ||
                      ((state == ST_PLAY) && (top_id > sfx_id));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            req_q   <= 3'b000;
            cd_cnt  <= 4'd0;
            gate    <= 1'b0;
            sfx_id  <= 2'd0;
            step    <= 4'd0;
            done    <= 1'b0;
            pending <= 3'b000;
        end else begin
            req_q   <= req;
            done    <= 1'b0;
            // A rise on the bit being granted re-arms it: set wins over clear.
            pending <= (pending & ~(do_grant ? grant_oh : 3'b000)) | set_vec;
            if (do_grant) begin
                sfx_id <= top_id;
                step   <= 4'd0;
                gate   <= 1'b1;
                state  <= ST_PLAY;
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (frame_tick) begin
                            if (step == LAST_STEP) begin
                                gate   <= 1'b0;
                                sfx_id <= 2'd0;
                                step   <= 4'd0;
                                done   <= 1'b1;
                                cd_cnt <= 4'd0;
                                state  <= (COOLDOWN_FRAMES == 0) ? ST_IDLE : ST_COOL;
                            end else begin
                                step <= step + 4'd1;
                            end
                        end
                    end
                    ST_COOL: begin
                        if (frame_tick) begin
                            if (cd_cnt == CD_LAST) state  <= ST_IDLE;
                            else                   cd_cnt <= cd_cnt + 4'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign step8 = {4'b0000, step};

    always_comb begin
        note = 8'd0;
        case (sfx_id)
            2'd1:    note = 8'd60 + {2'b00, step, 2'b00};
            2'd2:    note = 8'd120 - (step8 * 8'd6);
            2'd3:    note = 8'd200 - (step8 * 8'd12);
            default: note = 8'd0;
        endcase
    end

endmodule

// File: tb/tb_sfx_event_scheduler.sv
// Bench for sfx_event_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_sfx_event_scheduler;

    localparam int SFX  = 8;
    localparam int COOL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b1;
    logic [2:0] req = 3'b000;
    logic       gate;
    logic [1:0] sfx_id;
    logic [3:0] step;
    logic [7:0] note;
    logic       done;
    logic [2:0] pending;

    int checks = 0;
    int errors = 0;

    sfx_event_scheduler #(.SFX_FRAMES(SFX), .COOLDOWN_FRAMES(COOL)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .enable(enable), .req(req),
        .gate(gate), .sfx_id(sfx_id), .step(step), .note(note), .done(done), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = silent/waiting, 1 = effect playing, 2 = cooling down.
    int       m_mode, m_id, m_step, m_cool_left;
    bit       m_done;
    bit [2:0] m_pend, m_prev_req;

    task automatic model_reset();
        m_mode = 0; m_id = 0; m_step = 0; m_cool_left = 0;
        m_done = 0; m_pend = 3'b000; m_prev_req = 3'b000;
    endtask

    task automatic model_edge();
        int best;
        bit [2:0] rise;
        bit [2:0] served;
        best = 0;
        for (int i = 0; i < 3; i++) if (m_pend[i]) best = i + 1;
        rise   = req & ~m_prev_req;
        served = 3'b000;
        m_done = 0;
        if ((m_mode == 0 && best > 0) || (m_mode == 1 && best > m_id)) begin
            served[best-1] = 1'b1;
            m_id = best; m_step = 0; m_mode = 1;
        end else if (m_mode == 1 && frame_tick) begin
            if (m_step == SFX - 1) begin
                m_id = 0; m_step = 0; m_done = 1;
                m_cool_left = COOL;
                m_mode = (COOL > 0) ? 2 : 0;
            end else begin
                m_step++;
            end
        end else if (m_mode == 2 && frame_tick) begin
            m_cool_left--;
            if (m_cool_left == 0) m_mode = 0;
        end
        m_pend = (m_pend & ~served) | (enable ? rise : 3'b000);
        m_prev_req = req;
    endtask

    function automatic logic [7:0] exp_note(int id, int st);
        int v;
        case (id)
            1:       v = 60 + 4 * st;
            2:       v = 120 - 6 * st;
            3:       v = 200 - 12 * st;
            default: v = 0;
        endcase
        return 8'(((v % 256) + 256) % 256);
    endfunction

    function automatic logic [18:0] exp_vec();
        return {(m_mode == 1), 2'(m_id), 4'(m_step), exp_note(m_id, m_step), m_done, m_pend};
    endfunction

    wire [18:0] dut_vec = {gate, sfx_id, step, note, done, pending};

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        req = 3'b000; enable = 1'b1; frame_tick = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (gate !== 1'b0)      begin errors++; $display("FAIL reset_gate got %b want 0", gate); end
        checks++; if (sfx_id !== 2'd0)    begin errors++; $display("FAIL reset_sfx_id got %0d want 0", sfx_id); end
        checks++; if (step !== 4'd0)      begin errors++; $display("FAIL reset_step got %0d want 0", step); end
        checks++; if (note !== 8'd0)      begin errors++; $display("FAIL reset_note got %0d want 0", note); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got %b want 000", pending); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_single_sheep();
        int dones;
        do_reset();
        req = 3'b001; cyc();
        checks++; if (pending !== 3'b001 || gate !== 1'b0) begin errors++; $display("FAIL latch_latency pending=%b gate=%b want 001/0", pending, gate); end
        req = 3'b000; cyc();
        checks++; if (gate !== 1'b1 || sfx_id !== 2'd1 || note !== 8'd60 || pending !== 3'b000)
            begin errors++; $display("FAIL grant_latency gate=%b id=%0d note=%0d pend=%b want 1/1/60/000", gate, sfx_id, note, pending); end
        for (int t = 0; t < SFX; t++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL sheep_tick%0d got %h want %h", t, dut_vec, exp_vec()); end
            if (t < SFX - 1) begin
                checks++; if (note !== 8'(60 + 4 * (t + 1))) begin errors++; $display("FAIL sheep_note%0d got %0d want %0d", t, note, 60 + 4 * (t + 1)); end
            end
            cyc();
        end
        // The done pulse lands on the final tick and is gone one cycle later.
        checks++; if (done !== 1'b0 || gate !== 1'b0 || sfx_id !== 2'd0) begin errors++; $display("FAIL sheep_end done=%b gate=%b id=%0d want 0/0/0", done, gate, sfx_id); end
        dones = 0;
        for (int t = 0; t < COOL + 2; t++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            if (done) dones++;
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL sheep_cool%0d got %h want %h", t, dut_vec, exp_vec()); end
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL cool_no_done got %0d want 0", dones); end
    endtask

    task automatic test_preempt();
        do_reset();
        req = 3'b001; cyc(); req = 3'b000; cyc();
        for (int t = 0; t < 3; t++) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
        checks++; if (step !== 4'd3 || sfx_id !== 2'd1) begin errors++; $display("FAIL pre_step got id=%0d step=%0d want 1/3", sfx_id, step); end
        req = 3'b100; cyc();
        req = 3'b000; frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        checks++; if (sfx_id !== 2'd3 || step !== 4'd0 || note !== 8'd200 || done !== 1'b0)
            begin errors++; $display("FAIL preempt id=%0d step=%0d note=%0d done=%b want 3/0/200/0", sfx_id, step, note, done); end
        req = 3'b010; cyc(); req = 3'b000;
        checks++; if (pending !== 3'b010 || sfx_id !== 2'd3) begin errors++; $display("FAIL sword_waits pend=%b id=%0d want 010/3", pending, sfx_id); end
        for (int t = 0; t < SFX + COOL; t++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL preempt_run%0d got %h want %h", t, dut_vec, exp_vec()); end
        end
        checks++; if (sfx_id !== 2'd2 || note !== 8'd120 || pending !== 3'b000) begin errors++; $display("FAIL sword_plays id=%0d note=%0d pend=%b want 2/120/000", sfx_id, note, pending); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 3'b101; cyc(); req = 3'b000; cyc();
        checks++; if (sfx_id !== 2'd3 || note !== 8'd200 || pending !== 3'b001) begin errors++; $display("FAIL simul_first id=%0d note=%0d pend=%b want 3/200/001", sfx_id, note, pending); end
        frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
        checks++; if (note !== 8'd188) begin errors++; $display("FAIL simul_note got %0d want 188", note); end
        cyc();
        for (int t = 1; t < SFX + COOL; t++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL simul_run%0d got %h want %h", t, dut_vec, exp_vec()); end
        end
        checks++; if (sfx_id !== 2'd1 || note !== 8'd60) begin errors++; $display("FAIL simul_second id=%0d note=%0d want 1/60", sfx_id, note); end
    endtask

    task automatic test_hold_and_enable();
        int dones;
        do_reset();
        dones = 0;
        req = 3'b001;
        for (int c = 0; c < 100; c++) begin
            frame_tick = (c % 5 == 4);
            cyc();
            if (done) dones++;
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL hold_c%0d got %h want %h", c, dut_vec, exp_vec()); end
        end
        frame_tick = 1'b0;
        checks++; if (dones != 1 || pending !== 3'b000) begin errors++; $display("FAIL hold_once dones=%0d pend=%b want 1/000", dones, pending); end
        req = 3'b000; cyc();
        enable = 1'b0; req = 3'b010; cyc(); cyc();
        checks++; if (pending !== 3'b000 || gate !== 1'b0) begin errors++; $display("FAIL enable_drop pend=%b gate=%b want 000/0", pending, gate); end
        req = 3'b000; enable = 1'b1; cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 3'b001; cyc(); req = 3'b000; cyc();
        for (int t = 0; t < 5; t++) begin frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc(); end
        checks++; if (step !== 4'd5 || note !== 8'd80) begin errors++; $display("FAIL mid_step got step=%0d note=%0d want 5/80", step, note); end
        req = 3'b100; #2;
        rst_n = 1'b0; #1;
        checks++; if ({gate, sfx_id, step, note, done, pending} !== 19'd0) begin errors++; $display("FAIL async_reset got %h want 0", dut_vec); end
        req = 3'b000; #1;
        rst_n = 1'b1; model_reset();
        cyc();
        checks++; if (pending !== 3'b000 || gate !== 1'b0) begin errors++; $display("FAIL post_reset pend=%b gate=%b want 000/0", pending, gate); end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            enable     = ($urandom_range(0, 9) != 0);
            frame_tick = ($urandom_range(0, 3) == 0);
            cyc();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                if (bad < 10) $display("FAIL random_c%0d got %h want %h", c, dut_vec, exp_vec());
                bad++;
            end
        end
        req = 3'b000; enable = 1'b1; frame_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_sheep();
        test_preempt();
        test_simultaneous();
        test_hold_and_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sfx_event_scheduler.md
Name: sfx_event_scheduler

Overview:
- Sequences the APU sound-effect voice from game collision events.
- Latches rising edges of the three collision request lines (sheep-dragon, sword-dragon, player-dragon) and arbitrates between them by fixed priority.
- Plays one effect at a time as a frame-stepped note sequence, with preemption by higher-priority events and a cooldown between effects.
- Sits between the collision inputs and the AudioProcessingUnit tone generator, clocked by the frame tick derived from the hvsync generator.

Parameters:
- SFX_FRAMES, 8, effect length in frames; legal range 1..16.
- COOLDOWN_FRAMES, 2, silent frames after normal completion; legal range 0..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- frame_tick  input  1  one-cycle pulse per video frame (hpos==0 && vpos==0)
- enable  input  1  high = accept new requests
- req  input  3  level collision inputs: bit0 sheep-dragon, bit1 sword-dragon, bit2 player-dragon
- gate  output  1  voice on
- sfx_id  output  2  0 none, 1 sheep, 2 sword, 3 player
- step  output  4  frame index within current effect
- note  output  8  tone divider for the APU voice
- done  output  1  one-cycle pulse on normal completion
- pending  output  3  latched, not-yet-served requests

Behaviour:
- Reset (async assert, sync deassert by clk): state IDLE; gate=0, sfx_id=0, step=0, note=0, done=0, pending=0; req history register cleared. Reset mid-effect kills the effect immediately.
- Edge detect: req_q <= req every clk; rise = req & ~req_q. At a clock edge where rise[i] and enable are both high, pending[i] is set. Level-held req does not re-trigger. enable=0 drops rises; it does not affect an effect in progress.
- Grant select: highest set bit of pending. Priority order: player(2) > sword(1) > sheep(0).
- Grant action: at the grant edge, clear the granted pending bit and load sfx_id=i+1, step=0, gate=1.
- Set/clear collision: if a rise on the same bit coincides with its clear, set wins (bit stays 1).
- Latency: req high sampled at edge k -> pending visible after k -> gate/sfx_id visible after edge k+1 (IDLE case).
- State machine:
  - IDLE: gate=0. If pending!=0, grant and go to PLAY.
  - PLAY, checks in priority order each cycle:
    - (a) Preempt: if a pending bit of strictly higher priority than the current sfx_id is set, re-grant at this edge (new id, step=0, stay in PLAY). No done pulse. A frame_tick in the same cycle is ignored.
    - (b) Complete: on frame_tick with step==SFX_FRAMES-1, set gate=0, sfx_id=0, step=0, pulse done for one cycle. Go to COOLDOWN, or to IDLE if COOLDOWN_FRAMES==0.
    - (c) Advance: on any other frame_tick, step+1.
    - A frame_tick in the grant cycle does not advance step.
    - Equal- or lower-priority requests stay pending.
  - COOLDOWN: gate=0. Count frame_ticks. After COOLDOWN_FRAMES ticks go to IDLE. Pending requests keep latching and are not served until IDLE. Preemption is not applied in COOLDOWN.
- Note generation: combinational from registered sfx_id/step, 8-bit modulo arithmetic.
  - id1: note = 60 + 4*step
  - id2: note = 120 - 6*step
  - id3: note = 200 - 12*step
  - id0: note = 0
- All outputs except note are registered.

Test Plan:
- Reset then req=3'b001 for 1 cycle -> pending=001 after edge k; gate=1, sfx_id=1, note=60 after edge k+1; pending=000.
- Sheep effect with 8 frame_ticks (SFX_FRAMES=8) -> step 0..7, note 60,64..88. On 8th tick: done=1 for one cycle, gate=0, sfx_id=0. 2 ticks of cooldown, then IDLE.
- Sheep playing at step 3, then req[2] rise -> next edge sfx_id=3, step=0, note=200, no done pulse. Sword rise during player effect -> sword stays pending=010 and plays after player effect + cooldown.
- req[0] and req[2] rise in the same cycle -> player served first (note 200, 188, ...); sheep served after cooldown.
- req held high for 100 cycles -> exactly one pending set and one effect. enable=0 with rise -> pending unchanged.
- Assert rst_n=0 mid-effect at step 5 -> all outputs 0 without waiting for clk; after release, IDLE with pending=000.
